// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry, state encodings and sequencer step encoding
// for the single-player tennis game.
// No ports. Imported by pong_ball_step and pong_game_ctrl.
package pong_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int PADDLE_X     = 16;
  localparam int PADDLE_W     = 8;
  localparam int PADDLE_H     = 64;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_STEP  = 4;
  localparam int BALL_STEP    = 2;
  localparam int PAUSE_FRAMES = 60;

  // Derived geometry
  localparam int FACE_X       = PADDLE_X + PADDLE_W;          // 24
  localparam int PADDLE_Y_MAX = V_ACTIVE - PADDLE_H;          // 416
  localparam int BALL_X_MAX   = H_ACTIVE - BALL_SIZE;         // 632
  localparam int BALL_Y_MAX   = V_ACTIVE - BALL_SIZE;         // 472
  localparam int PADDLE_Y_RST = (V_ACTIVE - PADDLE_H) / 2;    // 208
  localparam int GLUE_DY      = (PADDLE_H - BALL_SIZE) / 2;   // 28, ball centred on paddle

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    MISS = 2'd2,
    OVER = 2'd3
  } game_state_t;

  typedef enum logic [1:0] {
    STEP_WAIT = 2'd0,
    STEP_S1   = 2'd1,
    STEP_S2   = 2'd2,
    STEP_S3   = 2'd3
  } step_t;

endpackage

// File: rtl/pong_ball_step.sv
// pong_ball_step: combinational one-frame ball move for the PLAY state.
// Applies wall bounces, paddle return and left-edge miss; X and Y resolve
// independently so a corner flips both directions in the same frame.
// Ports:
//   ball_x, ball_y          current ball top-left corner
//   dx_neg, dy_neg          current direction (1 = moving left / up)
//   paddle_y                paddle top edge already updated for this frame
//   next_x, next_y          ball position after this frame
//   next_dx_neg/next_dy_neg direction after this frame
//   hit, miss               paddle return / ball lost past the left edge
module pong_ball_step
  import pong_pkg::*;
(
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic       dx_neg,
  input  logic       dy_neg,
  input  logic [8:0] paddle_y,
  output logic [9:0] next_x,
  output logic [8:0] next_y,
  output logic       next_dx_neg,
  output logic       next_dy_neg,
  output logic       hit,
  output logic       miss
);

  localparam logic [10:0] STEP  = 11'(BALL_STEP);
  localparam logic [10:0] FACE  = 11'(FACE_X);
  localparam logic [10:0] X_MAX = 11'(BALL_X_MAX);
  localparam logic [10:0] Y_MAX = 11'(BALL_Y_MAX);
  localparam logic [10:0] BSIZE = 11'(BALL_SIZE);
  localparam logic [10:0] PH    = 11'(PADDLE_H);

  // 11-bit working copies so sums and differences never wrap
  logic [10:0] x, y, py;
  logic        overlap_y;

  assign x  = {1'b0, ball_x};
  assign y  = {2'b0, ball_y};
  assign py = {2'b0, paddle_y};
  assign overlap_y = (y + BSIZE > py) && (y < py + PH);

  always_comb begin
    next_x      = ball_x;
    next_y      = ball_y;
    next_dx_neg = dx_neg;
    next_dy_neg = dy_neg;
    hit         = 1'b0;
    miss        = 1'b0;

    if (dy_neg) begin
      if (y < STEP) begin
        next_y      = '0;
        next_dy_neg = 1'b0;
      end else begin
        next_y = 9'(y - STEP);
      end
    end else begin
      if (y + STEP > Y_MAX) begin
        next_y      = 9'(Y_MAX);
        next_dy_neg = 1'b1;
      end else begin
        next_y = 9'(y + STEP);
      end
    end

    if (!dx_neg) begin
      if (x + STEP > X_MAX) begin
        next_x      = 10'(X_MAX);
        next_dx_neg = 1'b1;
      end else begin
        next_x = 10'(x + STEP);
      end
    end else begin
      // Return only when this step would carry the ball across the face
      // (x >= FACE guarantees x - STEP cannot underflow).
      if ((x >= FACE) && (x - STEP < FACE) && overlap_y) begin
        next_x      = 10'(FACE);
        next_dx_neg = 1'b0;
        hit         = 1'b1;
      end else if (x < STEP) begin
        next_x = '0;
        miss   = 1'b1;
      end else begin
        next_x = 10'(x - STEP);
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame game sequencer. On each accepted frameTick it
// moves the paddle, moves the ball, resolves collisions and keeps score.
// Ports:
//   clock, resetN        system clock, synchronous active-low reset
//   frameTick            1-cycle pulse at start of vertical blank
//   up, down, serve      player request levels, sampled with frameTick
//   paddleY, ballX/Y     object positions for the video generator
//   hits, misses         saturating score counters
//   gameState            0 IDLE, 1 PLAY, 2 MISS, 3 OVER
//   updateDone           1-cycle pulse while freshly committed values show
//   seqStep              debug view of the update sequencer step
// Handshake: frameTick is a fire-and-forget request; it is accepted only in
// STEP_WAIT and dropped while S1..S3 run. updateDone marks the single cycle
// (S3) in which the new positions and scores first appear on the outputs.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clock,
  input  logic       resetN,
  input  logic       frameTick,
  input  logic       up,
  input  logic       down,
  input  logic       serve,
  output logic [8:0] paddleY,
  output logic [9:0] ballX,
  output logic [8:0] ballY,
  output logic [7:0] hits,
  output logic [3:0] misses,
  output logic [1:0] gameState,
  output logic       updateDone,
  output logic [1:0] seqStep
);

  step_t       step;
  game_state_t game_state;
  logic        up_q, down_q, serve_q;
  logic        dx_neg, dy_neg;
  logic [5:0]  pause_cnt;
  logic [8:0]  paddle_new;
  logic [9:0]  paddle_calc;

  logic [9:0]  bs_x;
  logic [8:0]  bs_y;
  logic        bs_dx_neg, bs_dy_neg, bs_hit, bs_miss;

  assign gameState = game_state;
  assign seqStep   = step;

  // Paddle move from the sampled direction levels; clamped to the screen.
  always_comb begin
    paddle_calc = {1'b0, paddleY};
    if (up_q && !down_q) begin
      paddle_calc = (paddleY < 9'(PADDLE_STEP)) ? 10'd0
                                                : 10'(paddleY) - 10'(PADDLE_STEP);
    end else if (down_q && !up_q) begin
      paddle_calc = (10'(paddleY) + 10'(PADDLE_STEP) > 10'(PADDLE_Y_MAX))
                    ? 10'(PADDLE_Y_MAX) : 10'(paddleY) + 10'(PADDLE_STEP);
    end
  end

  pong_ball_step u_ball_step (
    .ball_x      (ballX),
    .ball_y      (ballY),
    .dx_neg      (dx_neg),
    .dy_neg      (dy_neg),
    .paddle_y    (paddle_new),
    .next_x      (bs_x),
    .next_y      (bs_y),
    .next_dx_neg (bs_dx_neg),
    .next_dy_neg (bs_dy_neg),
    .hit         (bs_hit),
    .miss        (bs_miss)
  );

  // S1 registers the new paddle; the ball step sees it during S2 and the
  // whole frame commits on the S2->S3 edge, so S3 is the first cycle that
  // shows the new values.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      step       <= STEP_WAIT;
      game_state <= IDLE;
      paddleY    <= 9'(PADDLE_Y_RST);
      paddle_new <= 9'(PADDLE_Y_RST);
      ballX      <= 10'(FACE_X);
      ballY      <= 9'(PADDLE_Y_RST + GLUE_DY);
      hits       <= '0;
      misses     <= '0;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      pause_cnt  <= '0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      serve_q    <= 1'b0;
      updateDone <= 1'b0;
    end else begin
      updateDone <= 1'b0;
      unique case (step)
        STEP_WAIT: begin
          if (frameTick) begin
            up_q    <= up;
            down_q  <= down;
            serve_q <= serve;
            step    <= STEP_S1;
          end
        end
        STEP_S1: begin
          paddle_new <= (game_state == OVER) ? paddleY : paddle_calc[8:0];
          step       <= STEP_S2;
        end
        STEP_S2: begin
          paddleY    <= paddle_new;
          updateDone <= 1'b1;
          step       <= STEP_S3;
          unique case (game_state)
            IDLE: begin
              ballX <= 10'(FACE_X);
              ballY <= paddle_new + 9'(GLUE_DY);
              if (serve_q) begin
                game_state <= PLAY;
                dx_neg     <= 1'b0;
                dy_neg     <= 1'b0;
              end
            end
            PLAY: begin
              ballX  <= bs_x;
              ballY  <= bs_y;
              dx_neg <= bs_dx_neg;
              dy_neg <= bs_dy_neg;
              if (bs_hit && hits != 8'hFF) hits <= hits + 8'd1;
              if (bs_miss) begin
                if (misses != 4'hF) misses <= misses + 4'd1;
                pause_cnt  <= '0;
                game_state <= MISS;
              end
            end
            MISS: begin
              if (pause_cnt == 6'(PAUSE_FRAMES - 1)) begin
                pause_cnt <= '0;
                if (misses == 4'hF) begin
                  game_state <= OVER;
                end else begin
                  game_state <= IDLE;
                  ballX      <= 10'(FACE_X);
                  ballY      <= paddle_new + 9'(GLUE_DY);
                end
              end else begin
                pause_cnt <= pause_cnt + 6'd1;
              end
            end
            OVER: begin
              if (serve_q) begin
                hits       <= '0;
                misses     <= '0;
                dx_neg     <= 1'b0;
                dy_neg     <= 1'b0;
                game_state <= IDLE;
              end
            end
          endcase
        end
        STEP_S3: begin
          step <= STEP_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed bench for pong_game_ctrl. A vector table
// exercises the ball-step collision rules (including odd coordinates the
// full game never reaches); hand-written sequences cover reset, sequencer
// timing, paddle travel, serve, the miss/pause cycle and game over.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  logic       frameTick = 1'b0, up = 1'b0, down = 1'b0, serve = 1'b0;
  logic [8:0] paddleY, ballY;
  logic [9:0] ballX;
  logic [7:0] hits;
  logic [3:0] misses;
  logic [1:0] gameState, seqStep;
  logic       updateDone;

  pong_game_ctrl dut (
    .clock(clock), .resetN(resetN), .frameTick(frameTick), .up(up), .down(down),
    .serve(serve), .paddleY(paddleY), .ballX(ballX), .ballY(ballY), .hits(hits),
    .misses(misses), .gameState(gameState), .updateDone(updateDone), .seqStep(seqStep)
  );

  // Stand-alone ball step for the vector table
  logic [9:0] bs_x, bs_nx;
  logic [8:0] bs_y, bs_py, bs_ny;
  logic       bs_dxn, bs_dyn, bs_ndxn, bs_ndyn, bs_hit, bs_miss;

  pong_ball_step u_bs (
    .ball_x(bs_x), .ball_y(bs_y), .dx_neg(bs_dxn), .dy_neg(bs_dyn), .paddle_y(bs_py),
    .next_x(bs_nx), .next_y(bs_ny), .next_dx_neg(bs_ndxn), .next_dy_neg(bs_ndyn),
    .hit(bs_hit), .miss(bs_miss)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clock);
    resetN = 1'b0; frameTick = 1'b0; up = 1'b0; down = 1'b0; serve = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
  endtask

  // One full frame: tick, then return in the S3 cycle (updateDone high).
  task automatic do_frame(input logic u, input logic d, input logic s);
    @(negedge clock);
    up = u; down = d; serve = s; frameTick = 1'b1;
    @(negedge clock);
    frameTick = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  // ---------------- ball step vectors ----------------
  typedef struct {
    logic [9:0] x; logic [8:0] y; logic dxn; logic dyn; logic [8:0] py;
    logic [9:0] ex; logic [8:0] ey; logic edxn; logic edyn; logic ehit; logic emiss;
  } vec_t;

  vec_t vecs[17];

  logic [22:0] got_v, exp_v;
  int frames;
  bit found;

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs = '{
      //  x       y      dxn   dyn   py        ex      ey     edxn  edyn  hit   miss
      '{10'd300, 9'd1,   1'b0, 1'b1, 9'd200, 10'd302, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0}, // top bounce
      '{10'd25,  9'd230, 1'b1, 1'b0, 9'd200, 10'd24,  9'd232, 1'b0, 1'b0, 1'b1, 1'b0}, // paddle return
      '{10'd1,   9'd400, 1'b1, 1'b0, 9'd0,   10'd0,   9'd402, 1'b1, 1'b0, 1'b0, 1'b1}, // miss
      '{10'd100, 9'd471, 1'b0, 1'b0, 9'd0,   10'd102, 9'd472, 1'b0, 1'b1, 1'b0, 1'b0}, // bottom bounce
      '{10'd100, 9'd470, 1'b0, 1'b0, 9'd0,   10'd102, 9'd472, 1'b0, 1'b0, 1'b0, 1'b0}, // bottom exact
      '{10'd631, 9'd100, 1'b0, 1'b1, 9'd0,   10'd632, 9'd98,  1'b1, 1'b1, 1'b0, 1'b0}, // right wall
      '{10'd630, 9'd100, 1'b0, 1'b0, 9'd0,   10'd632, 9'd102, 1'b0, 1'b0, 1'b0, 1'b0}, // right exact
      '{10'd632, 9'd472, 1'b0, 1'b0, 9'd0,   10'd632, 9'd472, 1'b1, 1'b1, 1'b0, 1'b0}, // corner
      '{10'd25,  9'd192, 1'b1, 1'b0, 9'd200, 10'd23,  9'd194, 1'b1, 1'b0, 1'b0, 1'b0}, // just above paddle
      '{10'd25,  9'd263, 1'b1, 1'b0, 9'd200, 10'd24,  9'd265, 1'b0, 1'b0, 1'b1, 1'b0}, // paddle bottom row
      '{10'd25,  9'd264, 1'b1, 1'b0, 9'd200, 10'd23,  9'd266, 1'b1, 1'b0, 1'b0, 1'b0}, // just below paddle
      '{10'd24,  9'd230, 1'b1, 1'b1, 9'd200, 10'd24,  9'd228, 1'b0, 1'b1, 1'b1, 1'b0}, // at face
      '{10'd26,  9'd230, 1'b1, 1'b0, 9'd200, 10'd24,  9'd232, 1'b1, 1'b0, 1'b0, 1'b0}, // lands on face
      '{10'd2,   9'd100, 1'b1, 1'b0, 9'd400, 10'd0,   9'd102, 1'b1, 1'b0, 1'b0, 1'b0}, // reach 0, no miss
      '{10'd23,  9'd230, 1'b1, 1'b0, 9'd200, 10'd21,  9'd232, 1'b1, 1'b0, 1'b0, 1'b0}, // behind face
      '{10'd50,  9'd2,   1'b0, 1'b1, 9'd0,   10'd52,  9'd0,   1'b0, 1'b1, 1'b0, 1'b0}, // top exact
      '{10'd50,  9'd0,   1'b0, 1'b1, 9'd0,   10'd52,  9'd0,   1'b0, 1'b0, 1'b0, 1'b0}  // top flip at 0
    };

    for (int i = 0; i < 17; i++) begin
      bs_x = vecs[i].x; bs_y = vecs[i].y; bs_dxn = vecs[i].dxn;
      bs_dyn = vecs[i].dyn; bs_py = vecs[i].py;
      #1;
      got_v = {bs_nx, bs_ny, bs_ndxn, bs_ndyn, bs_hit, bs_miss};
      exp_v = {vecs[i].ex, vecs[i].ey, vecs[i].edxn, vecs[i].edyn, vecs[i].ehit, vecs[i].emiss};
      check($sformatf("ball_step_vec%0d", i), 32'(got_v), 32'(exp_v));
    end

    // ---- reset state ----
    do_reset();
    @(negedge clock);
    check("rst_paddleY", 32'(paddleY), 208);
    check("rst_ballX", 32'(ballX), 24);
    check("rst_ballY", 32'(ballY), 236);
    check("rst_hits", 32'(hits), 0);
    check("rst_misses", 32'(misses), 0);
    check("rst_state", 32'(gameState), 0);
    check("rst_updateDone", 32'(updateDone), 0);

    // ---- sequencer timing: outputs move only in the third cycle ----
    frameTick = 1'b1; down = 1'b1;
    @(negedge clock); frameTick = 1'b0;
    check("s1_updateDone", 32'(updateDone), 0);
    check("s1_paddleY", 32'(paddleY), 208);
    @(negedge clock);
    check("s2_updateDone", 32'(updateDone), 0);
    check("s2_paddleY", 32'(paddleY), 208);
    @(negedge clock);
    check("s3_updateDone", 32'(updateDone), 1);
    check("s3_paddleY", 32'(paddleY), 212);
    check("s3_ballY_glued", 32'(ballY), 240);
    @(negedge clock);
    check("s4_updateDone", 32'(updateDone), 0);

    // ---- frameTick while busy is dropped ----
    frameTick = 1'b1; down = 1'b1;
    @(negedge clock); frameTick = 1'b0;
    @(negedge clock); frameTick = 1'b1;          // lands in S2
    @(negedge clock); frameTick = 1'b0;
    repeat (6) @(negedge clock);
    check("busy_tick_paddleY", 32'(paddleY), 216);

    // ---- reset in the middle of S2 ----
    frameTick = 1'b1; down = 1'b1;
    @(negedge clock); frameTick = 1'b0;
    @(negedge clock); resetN = 1'b0;             // S2 cycle
    @(negedge clock); resetN = 1'b1;
    check("midrst_paddleY", 32'(paddleY), 208);
    check("midrst_ballY", 32'(ballY), 236);
    check("midrst_updateDone", 32'(updateDone), 0);
    @(negedge clock);
    check("midrst_updateDone2", 32'(updateDone), 0);
    check("midrst_seqStep", 32'(seqStep), 0);

    // ---- serve ----
    do_frame(1'b0, 1'b0, 1'b1);
    check("serve_state", 32'(gameState), 1);
    check("serve_ballX", 32'(ballX), 24);
    check("serve_ballY", 32'(ballY), 236);
    check("serve_updateDone", 32'(updateDone), 1);
    do_frame(1'b0, 1'b0, 1'b0);
    check("play1_ballX", 32'(ballX), 26);
    check("play1_ballY", 32'(ballY), 238);
    check("play1_state", 32'(gameState), 1);

    // ---- IDLE, up held 60 frames ----
    do_reset();
    for (int f = 1; f <= 60; f++) begin
      do_frame(1'b1, 1'b0, 1'b0);
      if (f == 51) check("up_f51_paddleY", 32'(paddleY), 4);
      if (f == 52) check("up_f52_paddleY", 32'(paddleY), 0);
    end
    check("up_f60_paddleY", 32'(paddleY), 0);
    check("up_f60_ballY", 32'(ballY), 28);
    check("up_f60_ballX", 32'(ballX), 24);
    check("up_f60_state", 32'(gameState), 0);

    // ---- 15 misses: serve from y=28, paddle parked at top ----
    // Ball runs to the right wall and back; it passes the face at y=298,
    // below the paddle, and is lost on the 622nd play frame.
    for (int m = 1; m <= 15; m++) begin
      do_frame(1'b1, 1'b0, 1'b1);
      check($sformatf("m%0d_serve_state", m), 32'(gameState), 1);
      frames = 0;
      found  = 1'b0;
      for (int f = 0; f < 1000 && !found; f++) begin
        do_frame(1'b1, 1'b0, 1'b0);
        frames++;
        if (gameState == 2'd2) found = 1'b1;
      end
      check($sformatf("m%0d_reached_miss", m), 32'(found), 1);
      check($sformatf("m%0d_frames", m), 32'(frames), 622);
      check($sformatf("m%0d_misses", m), 32'(misses), 32'(m));
      check($sformatf("m%0d_ballX", m), 32'(ballX), 0);
      check($sformatf("m%0d_hits", m), 32'(hits), 0);
      repeat (59) do_frame(1'b1, 1'b0, 1'b0);
      check($sformatf("m%0d_pause59_state", m), 32'(gameState), 2);
      check($sformatf("m%0d_pause59_ballX", m), 32'(ballX), 0);
      do_frame(1'b1, 1'b0, 1'b0);
      if (m == 15) begin
        check("m15_over_state", 32'(gameState), 3);
      end else begin
        check($sformatf("m%0d_pause60_state", m), 32'(gameState), 0);
        check($sformatf("m%0d_reglue_ballX", m), 32'(ballX), 24);
        check($sformatf("m%0d_reglue_ballY", m), 32'(ballY), 28);
      end
    end

    // ---- OVER: frozen, then serve restarts ----
    do_frame(1'b0, 1'b1, 1'b0);
    check("over_paddle_frozen", 32'(paddleY), 0);
    check("over_state", 32'(gameState), 3);
    check("over_misses", 32'(misses), 15);
    do_frame(1'b0, 1'b0, 1'b1);
    check("restart_state", 32'(gameState), 0);
    check("restart_misses", 32'(misses), 0);
    check("restart_hits", 32'(hits), 0);
    do_frame(1'b0, 1'b0, 1'b0);
    check("restart_glue_ballX", 32'(ballX), 24);
    check("restart_glue_ballY", 32'(ballY), 28);

    // ---- report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
